// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants and FSM state type for the LCD frame writer.
// Imported by lcd_xfer and lcd_frame_writer.
package lcd_pkg;
  localparam int LCD_COLS  = 16;
  localparam int LCD_ROWS  = 2;
  localparam int LCD_CELLS = LCD_COLS * LCD_ROWS;

  localparam logic [7:0] LCD_CMD_ROW0   = 8'h80;
  localparam logic [7:0] LCD_CMD_ROW1   = 8'hC0;
  localparam logic [7:0] LCD_CHAR_SPACE = 8'h20;

  localparam int LCD_FRAME_LEN = 34;

  typedef enum logic [2:0] {
    BOOT,
    IDLE,
    WAIT_RDY,
    STROBE,
    WAIT_HI,
    WAIT_LO,
    NEXT
  } fw_state_t;
endpackage

// File: rtl/lcd_xfer.sv
// lcd_xfer: one d_in/data_ready/busy_flag transaction with rise timeout.
// Ports: clock, reset_n, start, word in; lcd_d_in, lcd_data_ready, done, timeout out.
module lcd_xfer
  import lcd_pkg::*;
#(
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [8:0] word,
  input  logic       lcd_busy,
  output logic [8:0] lcd_d_in,
  output logic       lcd_data_ready,
  output logic       done,
  output logic       timeout
);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(BUSY_TIMEOUT - 1);

  fw_state_t     state;
  logic [TW-1:0] timer;
  logic          hi_expired;

  // Last allowed WAIT_HI cycle with busy still low.
  assign hi_expired = (state == WAIT_HI) && !lcd_busy
                   && (timer == T_LAST);
  assign timeout = hi_expired;
  assign done = hi_expired
             || ((state == WAIT_LO) && !lcd_busy);
  assign lcd_data_ready = (state == STROBE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      timer    <= '0;
      lcd_d_in <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) state <= WAIT_RDY;
        WAIT_RDY: begin
          if (!lcd_busy) begin
            lcd_d_in <= word;
            state    <= STROBE;
          end
        end
        STROBE: begin
          timer <= '0;
          state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (lcd_busy) state <= WAIT_LO;
          else if (hi_expired) state <= IDLE;
          else timer <= timer + TW'(1);
        end
        WAIT_LO: if (!lcd_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/lcd_frame_writer.sv
// lcd_frame_writer: 32-byte LCD shadow, streams 34-transaction frames when dirty.
// Ports: clock, reset_n, wr_*, refresh_req, lcd_busy in; lcd_*, frame_* , timeout_err out.
module lcd_frame_writer
  import lcd_pkg::*;
#(
  parameter int STARTUP_CYCLES = 8,
  parameter int BUSY_TIMEOUT   = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       refresh_req,
  input  logic       lcd_busy,
  output logic [8:0] lcd_d_in,
  output logic       lcd_data_ready,
  output logic       frame_busy,
  output logic       frame_done,
  output logic       timeout_err
);
  localparam int BW = $clog2(STARTUP_CYCLES + 1);
  localparam logic [BW-1:0] BOOT_LAST = BW'(STARTUP_CYCLES - 1);
  localparam logic [5:0] LAST_IDX = 6'(LCD_FRAME_LEN - 1);

  fw_state_t     state;
  logic [7:0]    shadow [LCD_CELLS];
  logic          dirty;
  logic          start;
  logic [5:0]    idx;
  logic [BW-1:0] boot_cnt;
  logic [8:0]    word;
  logic [5:0]    idx_m1;
  logic [5:0]    idx_m2;
  logic          xfer_done;
  logic          xfer_timeout;

  assign idx_m1 = idx - 6'd1;
  assign idx_m2 = idx - 6'd2;

  always_comb begin
    word = {1'b1, LCD_CHAR_SPACE};
    unique case (1'b1)
      (idx == 6'd0):
        word = {1'b0, LCD_CMD_ROW0};
      (idx >= 6'd1 && idx <= 6'd16):
        word = {1'b1, shadow[idx_m1[4:0]]};
      (idx == 6'd17):
        word = {1'b0, LCD_CMD_ROW1};
      (idx >= 6'd18):
        word = {1'b1, shadow[idx_m2[4:0]]};
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LCD_CELLS; i++)
        shadow[i] <= LCD_CHAR_SPACE;
    end else if (wr_en) begin
      shadow[wr_addr] <= wr_data;
    end
  end

  // WAIT_RDY here covers the whole in-flight transaction.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= BOOT;
      boot_cnt    <= '0;
      dirty       <= 1'b1;
      idx         <= '0;
      start       <= 1'b0;
      frame_busy  <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      start      <= 1'b0;
      frame_done <= 1'b0;
      if (xfer_timeout) timeout_err <= 1'b1;
      // Set beats the IDLE clear.
      if (wr_en || refresh_req) dirty <= 1'b1;
      else if (state == IDLE) dirty <= 1'b0;
      unique case (state)
        BOOT: begin
          if (boot_cnt == BOOT_LAST) state <= IDLE;
          else boot_cnt <= boot_cnt + BW'(1);
        end
        IDLE: begin
          if (dirty) begin
            idx        <= '0;
            frame_busy <= 1'b1;
            start      <= 1'b1;
            state      <= WAIT_RDY;
          end
        end
        WAIT_RDY: if (xfer_done) state <= NEXT;
        NEXT: begin
          if (idx == LAST_IDX) begin
            frame_done <= 1'b1;
            frame_busy <= 1'b0;
            state      <= IDLE;
          end else begin
            idx   <= idx + 6'd1;
            start <= 1'b1;
            state <= WAIT_RDY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  lcd_xfer #(
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) u_xfer (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .word           (word),
    .lcd_busy       (lcd_busy),
    .lcd_d_in       (lcd_d_in),
    .lcd_data_ready (lcd_data_ready),
    .done           (xfer_done),
    .timeout        (xfer_timeout)
  );
endmodule
